// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: extends an asynchronous 4-bit ripple counter with a wrap counter, error/overflow flags, match pulse and snapshot handshake
module ripple_count_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        cnt_in,
    input  logic [WRAP_W+3:0] match_val,
    input  logic              err_clr,
    input  logic              snap_req,
    input  logic              snap_ready,
    output logic [WRAP_W+3:0] ext_count,
    output logic [WRAP_W+3:0] snap_data,
    output logic              snap_valid,
    output logic              match_pulse,
    output logic              seq_err,
    output logic              ovf
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [3:0]        s1_q, s1_d, s2_q, s2_d, cur_q, cur_d, delta;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [1:0]        prime_q, prime_d;
    logic              primed, wrap_inc, bad;
    logic              seq_err_q, seq_err_d, ovf_q, ovf_d, match_pulse_q, match_pulse_d;
    logic [0:0]        state_q, state_d;
    logic [WRAP_W+3:0] snap_data_q, snap_data_d, ext_d;

    assign ext_count   = {wrap_q, cur_q};
    assign snap_data   = snap_data_q;
    assign snap_valid  = state_q == HOLD;
    assign match_pulse = match_pulse_q;
    assign seq_err     = seq_err_q;
    assign ovf         = ovf_q;

    // Next-state: sync chain, delta classification after priming, flags, match edge and snapshot FSM
    always_comb begin
        s1_d          = cnt_in;
        s2_d          = s1_q;
        delta         = s2_q - cur_q;
        primed        = prime_q == 2'd3;
        prime_d       = primed ? prime_q : prime_q + 2'd1;
        cur_d         = s2_q;
        wrap_inc      = primed && delta == 4'd1 && cur_q == 4'hF;
        bad           = primed && delta > 4'd1;
        wrap_d        = wrap_inc ? wrap_q + WRAP_W'(1) : wrap_q;
        ovf_d         = ovf_q | (wrap_inc & (&wrap_q));
        seq_err_d     = bad | (seq_err_q & ~err_clr);
        ext_d         = {wrap_d, cur_d};
        match_pulse_d = ext_d == match_val && ext_count != match_val;
        state_d       = state_q == IDLE ? (snap_req ? HOLD : IDLE) : (snap_ready ? IDLE : HOLD);
        snap_data_d   = (state_q == IDLE && snap_req) ? ext_count : snap_data_q;
    end

    // State registers, cleared asynchronously by reset_n
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q          <= '0;
            s2_q          <= '0;
            cur_q         <= '0;
            wrap_q        <= '0;
            prime_q       <= '0;
            seq_err_q     <= 1'b0;
            ovf_q         <= 1'b0;
            match_pulse_q <= 1'b0;
            state_q       <= IDLE;
            snap_data_q   <= '0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            cur_q         <= cur_d;
            wrap_q        <= wrap_d;
            prime_q       <= prime_d;
            seq_err_q     <= seq_err_d;
            ovf_q         <= ovf_d;
            match_pulse_q <= match_pulse_d;
            state_q       <= state_d;
            snap_data_q   <= snap_data_d;
        end
    end
endmodule
